// File: rtl/frontend_ras_pkg.sv
// Shared frontend constants for the return address stack and the
// pre-decoder's call/ret classification.
package frontend_ras_pkg;

    localparam int RAS_DEPTH_DEFAULT = 8;
    localparam int LINK_OFFSET = 4;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_storage.sv
// Return address stack entry array: one synchronous write port,
// one asynchronous read port, all entries cleared on reset.
module ras_storage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [ADDR_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [ADDR_WIDTH-1:0] rdata
);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

    // Entry array with single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/frontend_ras.sv
// Frontend return address stack with checkpoint/restore pointers.
// Optional RAS_STATS_EN adds saturating overflow/underflow counters.
module frontend_ras
    import frontend_ras_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pdec_valid,
    input  logic                  pdec_call,
    input  logic                  pdec_ret,
    input  logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  ras_pred_valid,
    output logic [ADDR_WIDTH-1:0] ras_pred_pc,
    output logic [PTR_W-1:0]      ras_ckpt_tos,
    output logic [PTR_W:0]        ras_ckpt_cnt,
    input  logic                  bru_flush,
    input  logic [PTR_W-1:0]      bru_tos,
    input  logic [PTR_W:0]        bru_cnt,
    output logic                  ras_empty
`ifdef RAS_STATS_EN
    ,
    output logic [31:0]           ras_ovf_cnt,
    output logic [31:0]           ras_udf_cnt
`endif
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PTR_W-1:0]      tos_q, tos_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we;
    logic [PTR_W-1:0]      waddr;
    logic [ADDR_WIDTH-1:0] link_pc;
    logic                  empty, full;
    logic                  act, push, pop, swap;
    logic                  push_ev, ovf_ev, udf_ev;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);
    assign act     = pdec_valid & ~bru_flush;
    assign push    = act & pdec_call & ~pdec_ret;
    assign pop     = act & pdec_ret & ~pdec_call;
    assign swap    = act & pdec_call & pdec_ret;
    assign push_ev = push | (swap & empty);
    assign ovf_ev  = push_ev & full;
    assign udf_ev  = pop & empty;
    assign link_pc = inst_pc + ADDR_WIDTH'(LINK_OFFSET);

    ras_storage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (link_pc),
        .raddr (tos_q),
        .rdata (ras_pred_pc)
    );

    // Next pointer/count and write request; flush wins over push/pop
    always_comb begin
        tos_d = tos_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = tos_q + PTR_ONE;
        if (bru_flush) begin
            tos_d = bru_tos;
            cnt_d = (bru_cnt > CNT_MAX) ? CNT_MAX : bru_cnt;
        end else if (push_ev) begin
            we    = 1'b1;
            tos_d = tos_q + PTR_ONE;
            cnt_d = full ? cnt_q : cnt_q + CNT_ONE;
        end else if (swap) begin
            we    = 1'b1;
            waddr = tos_q;
        end else if (pop && !empty) begin
            tos_d = tos_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Stack pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q <= '0;
            cnt_q <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    assign ras_pred_valid = pdec_valid & pdec_ret & ~empty;
    assign ras_ckpt_tos   = tos_q;
    assign ras_ckpt_cnt   = cnt_q;
    assign ras_empty      = empty;

`ifdef RAS_STATS_EN
    logic [31:0] ovf_cnt_q, ovf_cnt_d;
    logic [31:0] udf_cnt_q, udf_cnt_d;

    // Saturating event counters, independent of flush restores
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (ovf_ev && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 32'd1;
        if (udf_ev && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ras_ovf_cnt = ovf_cnt_q;
    assign ras_udf_cnt = udf_cnt_q;
`else
    logic unused_ev;
    assign unused_ev = ovf_ev ^ udf_ev;
`endif

endmodule
